// File: rtl/seq_shift_add_multiplier_if.sv
// Request/response bundle for seq_shift_add_multiplier.
// The signed_op wire exists only when SEQ_MULT_SIGNED_EN is defined.
interface seq_shift_add_multiplier_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;
`ifdef SEQ_MULT_SIGNED_EN
    logic               signed_op;

    modport master (output start, a, b, signed_op, input busy, done, product);
    modport slave  (input start, a, b, signed_op, output busy, done, product);
`else
    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
`endif
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add multiplier: one add per cycle, WIDTH steps, start/busy/done handshake.
// Optional two's-complement mode is enabled by defining SEQ_MULT_SIGNED_EN.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input logic                       clk,
    input logic                       rst,
    seq_shift_add_multiplier_if.slave bus
);
    localparam int            CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [WIDTH-1:0]   acc_hi_r;
    logic [CW-1:0]      cnt_r;
    logic               busy_r;
    logic               done_r;
    logic [2*WIDTH-1:0] product_r;

    logic [WIDTH:0]     addend_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH-1:0]   next_hi_s;
    logic [WIDTH-1:0]   next_lo_s;
    logic [2*WIDTH-1:0] raw_s;
    logic [2*WIDTH-1:0] result_s;
    logic [WIDTH-1:0]   cap_a_s;
    logic [WIDTH-1:0]   cap_b_s;

`ifdef SEQ_MULT_SIGNED_EN
    logic               neg_r;
    logic               cap_neg_s;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        if (is_signed && v[WIDTH-1]) begin
            magnitude = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            magnitude = v;
        end
    endfunction

    function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] v);
        negate = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction
`endif

    // One step: add multiplicand into the high half when the multiplier LSB is set, then shift {carry, acc} right.
    always_comb begin
        addend_s  = mplier_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}};
        sum_s     = {1'b0, acc_hi_r} + addend_s;
        next_hi_s = sum_s[WIDTH:1];
        next_lo_s = {sum_s[0], mplier_r[WIDTH-1:1]};
        raw_s     = {next_hi_s, next_lo_s};
    end

`ifdef SEQ_MULT_SIGNED_EN
    // Signed mode multiplies magnitudes; sign is restored when the product is loaded.
    always_comb begin
        cap_a_s   = magnitude(bus.a, bus.signed_op);
        cap_b_s   = magnitude(bus.b, bus.signed_op);
        cap_neg_s = bus.signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        if (neg_r) begin
            result_s = negate(raw_s);
        end else begin
            result_s = raw_s;
        end
    end
`else
    // Unsigned only: operands and result pass straight through.
    always_comb begin
        cap_a_s  = bus.a;
        cap_b_s  = bus.b;
        result_s = raw_s;
    end
`endif

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= {(2*WIDTH){1'b0}};
            cnt_r     <= {CW{1'b0}};
            mcand_r   <= {WIDTH{1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            acc_hi_r  <= {WIDTH{1'b0}};
`ifdef SEQ_MULT_SIGNED_EN
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        mcand_r  <= cap_a_s;
                        mplier_r <= cap_b_s;
                        acc_hi_r <= {WIDTH{1'b0}};
                        cnt_r    <= {CW{1'b0}};
`ifdef SEQ_MULT_SIGNED_EN
                        neg_r    <= cap_neg_s;
`endif
                        busy_r   <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        busy_r   <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                RUN: begin
                    acc_hi_r <= next_hi_s;
                    mplier_r <= next_lo_s;
                    cnt_r    <= cnt_r + CNT_ONE;
                    // The last step's shifted value goes straight into product.
                    if (cnt_r == LAST_STEP) begin
                        product_r <= result_s;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        busy_r    <= 1'b1;
                        done_r    <= 1'b0;
                        state_r   <= RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench: stimulus pushes expected products, per-instance monitors check busy/done/product each cycle.
module tb_seq_shift_add_multiplier;
    logic clk = 1'b0;
    logic rst4;
    logic rst8;
    always #5 clk = ~clk;

    seq_shift_add_multiplier_if #(.WIDTH(4)) bus4 ();
    seq_shift_add_multiplier_if #(.WIDTH(8)) bus8 ();

    seq_shift_add_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4));
    seq_shift_add_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(bus8));

    typedef struct packed {
        logic [15:0] prod;
        int          due;
    } exp_t;

    exp_t        q4[$];
    exp_t        q8[$];
    logic [15:0] last4 = 16'd0;
    logic [15:0] last8 = 16'd0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer multiply, operands sign-extended in signed mode, result kept to 2*w bits.
    function automatic logic [15:0] model(input int w, input logic [7:0] x, input logic [7:0] y, input bit sop);
        longint sx = longint'(x);
        longint sy = longint'(y);
        longint p;
        if (sop && x[w-1]) sx = sx - (longint'(1) << w);
        if (sop && y[w-1]) sy = sy - (longint'(1) << w);
        p = (sx * sy) & ((longint'(1) << (2 * w)) - 1);
        return 16'(p);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus4.done) begin
                chk("w4_busy_with_done", 32'(bus4.busy), 32'd0);
                if (q4.size() == 0) begin
                    chk("w4_unexpected_done", 32'(bus4.done), 32'd0);
                end else begin
                    chk("w4_done_cycle", cyc, q4[0].due);
                    chk("w4_product", 32'(bus4.product), 32'(q4[0].prod));
                    last4 = q4[0].prod;
                    void'(q4.pop_front());
                end
            end else begin
                chk("w4_busy", 32'(bus4.busy), 32'(q4.size() > 0 && cyc < q4[0].due));
                chk("w4_hold", 32'(bus4.product), 32'(last4));
                if (q4.size() > 0 && cyc >= q4[0].due) begin
                    chk("w4_missing_done", 32'(bus4.done), 32'd1);
                    last4 = q4[0].prod;
                    void'(q4.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus8.done) begin
                chk("w8_busy_with_done", 32'(bus8.busy), 32'd0);
                if (q8.size() == 0) begin
                    chk("w8_unexpected_done", 32'(bus8.done), 32'd0);
                end else begin
                    chk("w8_done_cycle", cyc, q8[0].due);
                    chk("w8_product", 32'(bus8.product), 32'(q8[0].prod));
                    last8 = q8[0].prod;
                    void'(q8.pop_front());
                end
            end else begin
                chk("w8_busy", 32'(bus8.busy), 32'(q8.size() > 0 && cyc < q8[0].due));
                chk("w8_hold", 32'(bus8.product), 32'(last8));
                if (q8.size() > 0 && cyc >= q8[0].due) begin
                    chk("w8_missing_done", 32'(bus8.done), 32'd1);
                    last8 = q8[0].prod;
                    void'(q8.pop_front());
                end
            end
        end
    end

    task automatic issue4(input logic [3:0] x, input logic [3:0] y, input bit sop, input bit keep);
        int guard = 0;
        @(negedge clk);
        while (bus4.busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("w4_wait_idle", 32'(bus4.busy), 32'd0);
        bus4.a     = x;
        bus4.b     = y;
        bus4.start = 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
        bus4.signed_op = sop;
`endif
        @(posedge clk);
        #1;
        q4.push_back('{prod: model(4, {4'd0, x}, {4'd0, y}, sop), due: cyc + 4});
        bus4.a = 4'($urandom);
        bus4.b = 4'($urandom);
        if (!keep) bus4.start = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] x, input logic [7:0] y, input bit sop, input bit keep);
        int guard = 0;
        @(negedge clk);
        while (bus8.busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("w8_wait_idle", 32'(bus8.busy), 32'd0);
        bus8.a     = x;
        bus8.b     = y;
        bus8.start = 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
        bus8.signed_op = sop;
`endif
        @(posedge clk);
        #1;
        q8.push_back('{prod: model(8, x, y, sop), due: cyc + 8});
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
        if (!keep) bus8.start = 1'b0;
    endtask

    initial begin
        int  guard;
        bit  sop;
        bit  keep;
        bus4.start = 1'b0; bus4.a = 4'd0; bus4.b = 4'd0;
        bus8.start = 1'b0; bus8.a = 8'd0; bus8.b = 8'd0;
`ifdef SEQ_MULT_SIGNED_EN
        bus4.signed_op = 1'b0;
        bus8.signed_op = 1'b0;
`endif
        rst4 = 1'b1;
        rst8 = 1'b1;
        @(posedge clk);
        #1 mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst4 = 1'b0;
        rst8 = 1'b0;

        issue4(4'd5, 4'd5, 1'b0, 1'b0);
        // Back-to-back with start held through DONE.
        issue4(4'd10, 4'd10, 1'b0, 1'b1);
        issue4(4'd15, 4'd15, 1'b0, 1'b0);

        // A second start two cycles into busy must be ignored.
        issue4(4'd3, 4'd7, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus4.a = 4'd12; bus4.b = 4'd11; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;

        // Reset mid-operation discards the result and the pending done.
        issue4(4'd7, 4'd9, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst4 = 1'b1;
        @(posedge clk);
        #1;
        q4.delete();
        last4 = 16'd0;
        rst4 = 1'b0;
        issue4(4'd6, 4'd11, 1'b0, 1'b0);

`ifdef SEQ_MULT_SIGNED_EN
        issue4(4'hD, 4'h5, 1'b1, 1'b0);
        issue4(4'h8, 4'h8, 1'b1, 1'b0);
        issue4(4'hD, 4'h5, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 30; i++) begin
            sop = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            sop = 1'($urandom);
`endif
            keep = (i != 29) && 1'($urandom);
            issue4(4'($urandom), 4'($urandom), sop, keep);
            if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        issue8(8'd255, 8'd255, 1'b0, 1'b0);
        issue8(8'd0, 8'd200, 1'b0, 1'b0);
`ifdef SEQ_MULT_SIGNED_EN
        issue8(8'h80, 8'h80, 1'b1, 1'b0);
`endif
        for (int i = 0; i < 20; i++) begin
            sop = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            sop = 1'($urandom);
`endif
            keep = (i != 19) && 1'($urandom);
            issue8(8'($urandom), 8'($urandom), sop, keep);
            if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        guard = 0;
        while ((q4.size() != 0 || q8.size() != 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_pending", 32'(q4.size() + q8.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
